// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and helpers for the system-ID boot checker
package sysid_check_pkg;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    IDLE    = 3'd1,
    ID_REQ  = 3'd2,
    ID_WAIT = 3'd3,
    TS_REQ  = 3'd4,
    TS_WAIT = 3'd5,
    FINISH  = 3'd6
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Bits needed to hold 0..n-1; never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sysid_timeout_counter.sv
// rtl/sysid_timeout_counter.sv - per-read cycle counter, expires on its LIMIT-th cycle
module sysid_timeout_counter
  import sysid_check_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - reads system ID and build timestamp over Avalon-MM and reports a match
module sysid_boot_checker
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e state_q, state_d;

  logic        avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        id_got_q, id_got_d;
  logic        ts_got_q, ts_got_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic in_req, in_read, accept, id_cap, ts_cap, expired, timeout_hit;
  logic seq_start, req_entry, finish_entry;

  assign in_req  = (state_q == ID_REQ) || (state_q == TS_REQ);
  assign in_read = in_req || (state_q == ID_WAIT) || (state_q == TS_WAIT);
  assign accept  = in_req && !avm_waitrequest;

  // Data counts only once the request has been accepted (same-cycle response allowed).
  assign id_cap = avm_readdatavalid &&
                  (((state_q == ID_REQ) && accept) || (state_q == ID_WAIT));
  assign ts_cap = avm_readdatavalid &&
                  (((state_q == TS_REQ) && accept) || (state_q == TS_WAIT));
  assign timeout_hit = in_read && expired && !id_cap && !ts_cap;

  assign seq_start    = (state_d == ID_REQ) && (state_q != ID_REQ);
  assign req_entry    = seq_start || ((state_d == TS_REQ) && (state_q != TS_REQ));
  assign finish_entry = (state_d == FINISH) && (state_q != FINISH);

  sysid_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clock),
    .rst_i     (reset),
    .clear_i   (req_entry),
    .enable_i  (in_read),
    .expired_o (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      avm_address_q <= ADDR_ID;
      avm_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      id_got_q      <= 1'b0;
      ts_got_q      <= 1'b0;
      id_value_q    <= 32'h0;
      ts_value_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      id_got_q      <= id_got_d;
      ts_got_q      <= ts_got_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = ID_REQ;
      IDLE:    if (start) state_d = ID_REQ;
      ID_REQ: begin
        if (id_cap)       state_d = TS_REQ;
        else if (expired) state_d = FINISH;
        else if (accept)  state_d = ID_WAIT;
      end
      ID_WAIT: begin
        if (id_cap)       state_d = TS_REQ;
        else if (expired) state_d = FINISH;
      end
      TS_REQ: begin
        if (ts_cap || expired) state_d = FINISH;
        else if (accept)       state_d = TS_WAIT;
      end
      TS_WAIT: if (ts_cap || expired) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    avm_read_d    = (state_d == ID_REQ) || (state_d == TS_REQ);
    avm_address_d = (state_d == TS_REQ) ? ADDR_TS : ADDR_ID;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FINISH);
    id_value_d    = id_cap ? avm_readdata : id_value_q;
    ts_value_d    = ts_cap ? avm_readdata : ts_value_q;
    id_got_d      = id_got_q | id_cap;
    ts_got_d      = ts_got_q | ts_cap;
    timeout_d     = timeout_q | timeout_hit;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    pass_d        = pass_q;
    if (seq_start) begin
      id_got_d  = 1'b0;
      ts_got_d  = 1'b0;
      timeout_d = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      pass_d    = 1'b0;
    end
    if (finish_entry) begin
      id_ok_d = id_got_d && (id_value_d == EXPECTED_ID);
      ts_ok_d = ts_got_d && (ts_value_d == EXPECTED_TIMESTAMP);
      pass_d  = id_ok_d && ts_ok_d && !timeout_d;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
